// File: rtl/alu_flag_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_flag_stage
// Purpose  : Single-entry output stage behind an ARM-style ALU. Evaluates the
//            condition field against the committed NZCV flags, registers the
//            ALU result, commits new flags for passing S-bit ops and counts
//            ops skipped by a failed condition (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module alu_flag_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:31] alu_o,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_cout,
  input  logic        s_bit,
  input  logic [0:3]  cond,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [0:31] out_result,
  output logic        out_exec,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v,
  output logic        alu_cin,
  output logic [0:15] skip_cnt
);

  localparam logic [0:15] C_SKIP_MAX = 16'hFFFF;

  logic        r_valid;
  logic [0:31] r_result;
  logic        r_exec;
  logic        r_n;
  logic        r_z;
  logic        r_c;
  logic        r_v;
  logic [0:15] r_skip;

  logic        w_pass;
  logic        w_accept;

  // Stage accepts whenever it is empty or its held op leaves this cycle.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  // Condition check always uses the committed flags, never the incoming ones.
  always_comb begin
    w_pass = 1'b0;
    case (cond)
      4'b0000: w_pass = r_z;
      4'b0001: w_pass = !r_z;
      4'b0010: w_pass = r_c;
      4'b0011: w_pass = !r_c;
      4'b0100: w_pass = r_n;
      4'b0101: w_pass = !r_n;
      4'b0110: w_pass = r_v;
      4'b0111: w_pass = !r_v;
      4'b1000: w_pass = r_c && !r_z;
      4'b1001: w_pass = !r_c || r_z;
      4'b1010: w_pass = (r_n == r_v);
      4'b1011: w_pass = (r_n != r_v);
      4'b1100: w_pass = !r_z && (r_n == r_v);
      4'b1101: w_pass = r_z || (r_n != r_v);
      4'b1110: w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  // Holding register, flag register and skip counter; flush wins over accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= 32'h0;
      r_exec   <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_skip   <= 16'h0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_result <= alu_o;
      r_exec   <= w_pass;
      if (w_pass && s_bit) begin
        r_n <= alu_n;
        r_z <= alu_z;
        r_c <= alu_cout;
        r_v <= alu_v;
      end
      if (!w_pass && (r_skip != C_SKIP_MAX)) begin
        r_skip <= r_skip + 16'd1;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_exec   = r_exec;
  assign flag_n     = r_n;
  assign flag_z     = r_z;
  assign flag_c     = r_c;
  assign flag_v     = r_v;
  assign alu_cin    = r_c;
  assign skip_cnt   = r_skip;

endmodule
`default_nettype wire

// File: tb/tb_alu_flag_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_flag_stage
// Purpose  : Directed vector table plus hand-written sequences for stall,
//            flush, counter saturation and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_flag_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] alu_o;
  logic        alu_n;
  logic        alu_z;
  logic        alu_v;
  logic        alu_cout;
  logic        s_bit;
  logic [0:3]  cond;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [0:31] out_result;
  logic        out_exec;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        alu_cin;
  logic [0:15] skip_cnt;

  int n_checks;
  int n_fail;

  alu_flag_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_o      (alu_o),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .alu_cout   (alu_cout),
    .s_bit      (s_bit),
    .cond       (cond),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_exec   (out_exec),
    .flag_n     (flag_n),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_v     (flag_v),
    .alu_cin    (alu_cin),
    .skip_cnt   (skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector: ALU inputs {n,z,v,cout}, then expected exec, {N,Z,C,V}, skip.
  typedef struct {
    logic [31:0] res;
    logic [3:0]  nzvco;
    logic        s;
    logic [3:0]  cnd;
    logic        e_exec;
    logic [3:0]  e_flags;
    logic [15:0] e_skip;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] r, input logic [3:0] f, input logic s, input logic [3:0] c);
    alu_o    = r;
    alu_n    = f[3];
    alu_z    = f[2];
    alu_v    = f[1];
    alu_cout = f[0];
    s_bit    = s;
    cond     = c;
  endtask

  function automatic logic [3:0] flags();
    return {flag_n, flag_z, flag_c, flag_v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(32'h0, 4'h0, 1'b0, 4'hE);

    //              res           nzvc  s   cnd   exec flags  skip
    vt[0]  = '{32'h0000_0000, 4'h4, 1'b1, 4'hE, 1'b1, 4'h4, 16'd0};
    vt[1]  = '{32'h8000_0000, 4'hF, 1'b1, 4'h1, 1'b0, 4'h4, 16'd1};
    vt[2]  = '{32'h1234_5678, 4'h1, 1'b1, 4'hE, 1'b1, 4'h2, 16'd1};
    vt[3]  = '{32'hA5A5_A5A5, 4'hF, 1'b0, 4'h2, 1'b1, 4'h2, 16'd1};
    vt[4]  = '{32'hF000_0001, 4'h8, 1'b1, 4'h8, 1'b1, 4'h8, 16'd1};
    vt[5]  = '{32'h0BAD_F00D, 4'h7, 1'b1, 4'hA, 1'b0, 4'h8, 16'd2};
    vt[6]  = '{32'h8000_0000, 4'hA, 1'b1, 4'hB, 1'b1, 4'h9, 16'd2};
    vt[7]  = '{32'h0000_0000, 4'h5, 1'b1, 4'hC, 1'b1, 4'h6, 16'd2};
    vt[8]  = '{32'h7FFF_FFFF, 4'hF, 1'b0, 4'hD, 1'b1, 4'h6, 16'd2};
    vt[9]  = '{32'hFFFF_FFFF, 4'hF, 1'b1, 4'hF, 1'b0, 4'h6, 16'd3};
    vt[10] = '{32'h0000_0010, 4'h0, 1'b1, 4'h0, 1'b1, 4'h0, 16'd3};
    vt[11] = '{32'h0000_0011, 4'hF, 1'b0, 4'h3, 1'b1, 4'h0, 16'd3};
    vt[12] = '{32'h0000_0012, 4'hF, 1'b1, 4'h4, 1'b0, 4'h0, 16'd4};
    vt[13] = '{32'h0000_0013, 4'hF, 1'b0, 4'h5, 1'b1, 4'h0, 16'd4};
    vt[14] = '{32'h0000_0014, 4'hF, 1'b1, 4'h6, 1'b0, 4'h0, 16'd5};
    vt[15] = '{32'h0000_0015, 4'hF, 1'b0, 4'h7, 1'b1, 4'h0, 16'd5};
    vt[16] = '{32'h0000_0016, 4'hF, 1'b0, 4'h9, 1'b1, 4'h0, 16'd5};

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_exec", out_exec, 0);
    check("rst_flags", flags(), 0);
    check("rst_skip", skip_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table, drain and accept on every edge
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].res, vt[i].nzvco, vt[i].s, vt[i].cnd);
      in_valid = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick();
      check($sformatf("v%0d_out_valid", i), out_valid, 1);
      check($sformatf("v%0d_out_result", i), out_result, vt[i].res);
      check($sformatf("v%0d_out_exec", i), out_exec, vt[i].e_exec);
      check($sformatf("v%0d_flags", i), flags(), vt[i].e_flags);
      check($sformatf("v%0d_alu_cin", i), alu_cin, vt[i].e_flags[1]);
      check($sformatf("v%0d_skip", i), skip_cnt, vt[i].e_skip);
    end
    in_valid = 1'b0;
    tick();
    check("drain_out_valid", out_valid, 0);

    // Stall: held op stays put while out_ready is low
    drive(32'hDEAD_BEEF, 4'h0, 1'b0, 4'hE);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    check("stall_load_valid", out_valid, 1);
    check("stall_load_result", out_result, 32'hDEAD_BEEF);
    drive(32'h1111_1111, 4'hF, 1'b1, 4'hF);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stall%0d_in_ready", k), in_ready, 0);
      tick();
      check($sformatf("stall%0d_result", k), out_result, 32'hDEAD_BEEF);
      check($sformatf("stall%0d_exec", k), out_exec, 1);
      check($sformatf("stall%0d_skip", k), skip_cnt, 5);
    end
    out_ready = 1'b1;
    drive(32'h1111_1111, 4'h0, 1'b0, 4'hE);
    #1;
    check("release_in_ready", in_ready, 1);
    tick();
    check("release_valid", out_valid, 1);
    check("release_result", out_result, 32'h1111_1111);
    in_valid = 1'b0;
    tick();
    check("release_drain", out_valid, 0);

    // Flush while full drops the held op and the incoming one
    drive(32'h2222_2222, 4'h0, 1'b0, 4'hE);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    check("flush_pre_valid", out_valid, 1);
    drive(32'h3333_3333, 4'hF, 1'b1, 4'hF);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_flags", flags(), 0);
    check("flush_skip", skip_cnt, 5);
    out_ready = 1'b1;
    tick();
    check("flush_stays_empty", out_valid, 0);

    // Saturation: fill the counter with never-ops, then one more
    drive(32'h4444_4444, 4'hF, 1'b1, 4'hF);
    in_valid = 1'b1;
    for (int k = 0; k < 65530; k++) @(posedge clk);
    #1;
    check("sat_reach", skip_cnt, 16'hFFFF);
    tick();
    check("sat_hold", skip_cnt, 16'hFFFF);
    check("sat_exec", out_exec, 0);
    check("sat_flags", flags(), 0);

    // Build nonzero flags, hold an op, then reset between edges
    drive(32'h5555_5555, 4'hF, 1'b1, 4'hE);
    tick();
    check("pre_rst_flags", flags(), 4'hF);
    drive(32'h6666_6666, 4'h0, 1'b1, 4'hE);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_result", out_result, 0);
    check("arst_out_exec", out_exec, 0);
    check("arst_flags", flags(), 0);
    check("arst_alu_cin", alu_cin, 0);
    check("arst_skip", skip_cnt, 0);
    check("arst_in_ready", in_ready, 1);
    tick();
    check("arst_hold_flags", flags(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h7777_7777, 4'h1, 1'b1, 4'hE);
    out_ready = 1'b1;
    tick();
    check("resume_valid", out_valid, 1);
    check("resume_result", out_result, 32'h7777_7777);
    check("resume_cin", alu_cin, 1);
    drive(32'h8888_8888, 4'h0, 1'b0, 4'h2);
    tick();
    check("cs_exec", out_exec, 1);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
